// File: rtl/ahb_to_axi_master_if.sv
// AXI4 bus bundle shared by the DMA bridge and its system-side slave.
// The Master modport drives the request channels; the Slave modport drives the responses.
interface AXI_BUS #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   logic                    aw_valid;
   logic                    aw_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic                    w_valid;
   logic                    w_ready;
   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic                    b_valid;
   logic                    b_ready;
   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic                    ar_lock;
   logic [3:0]              ar_cache;
   logic [2:0]              ar_prot;
   logic                    ar_valid;
   logic                    ar_ready;
   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic                    r_valid;
   logic                    r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output b_id, b_resp, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/ahb_to_axi_master.sv
// AHB-Lite slave to AXI4 master bridge for the DWC_otg DMA port: each accepted AHB beat
// becomes one single-beat, non-posted AXI transaction; AXI errors return as AHB ERROR.
//
// Handshake rule: an AXI transfer happens on a rising aclk edge where valid and ready are
// both high; valid, once raised, is held with stable payload until that edge and then drops.
module ahb_to_axi_master #(
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_hsel,
   input  logic [ADDR_WIDTH-1:0] s_haddr,
   input  logic [1:0]            s_htrans,
   input  logic                  s_hwrite,
   input  logic [2:0]            s_hsize,
   input  logic [2:0]            s_hburst,
   input  logic [31:0]           s_hwdata,
   input  logic                  s_hready,
   output logic                  s_hready_resp,
   output logic                  s_hresp,
   output logic [31:0]           s_hrdata,
   output logic [2:0]            dbg_state,
   AXI_BUS.Master                mst
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP, ST_DONE, ST_ERR1, ST_ERR2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic                  aw_valid_q;
   logic                  w_valid_q;
   logic                  ar_valid_q;
   logic                  b_ready_q;
   logic                  r_ready_q;

   logic accept;
   logic bad_xfer;
   logic aw_done;
   logic w_done;
   logic unused_inputs;

   assign accept = s_hsel & s_htrans[1] & s_hready &
                   ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR2));
   assign bad_xfer = (s_hsize > 3'd2) ||
                     ((s_hsize == 3'd1) && s_haddr[0]) ||
                     ((s_hsize == 3'd2) && (s_haddr[1:0] != 2'b00));

   // A channel counts as done once its valid has dropped or is handshaking this edge.
   assign aw_done = !aw_valid_q || mst.aw_ready;
   assign w_done  = !w_valid_q  || mst.w_ready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= ST_IDLE;
         addr_q        <= '0;
         size_q        <= 3'd0;
         s_hready_resp <= 1'b1;
         s_hresp       <= 1'b0;
         s_hrdata      <= 32'd0;
         aw_valid_q    <= 1'b0;
         w_valid_q     <= 1'b0;
         ar_valid_q    <= 1'b0;
         b_ready_q     <= 1'b0;
         r_ready_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
               if (accept) begin
                  addr_q        <= s_haddr;
                  size_q        <= s_hsize;
                  s_hready_resp <= 1'b0;
                  if (bad_xfer) begin
                     state   <= ST_ERR1;
                     s_hresp <= 1'b1;
                  end else if (s_hwrite) begin
                     state      <= ST_WR_REQ;
                     s_hresp    <= 1'b0;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                  end else begin
                     state      <= ST_RD_REQ;
                     s_hresp    <= 1'b0;
                     ar_valid_q <= 1'b1;
                  end
               end else begin
                  state         <= ST_IDLE;
                  s_hready_resp <= 1'b1;
                  s_hresp       <= 1'b0;
               end
            end
            ST_WR_REQ: begin
               if (mst.aw_ready) aw_valid_q <= 1'b0;
               if (mst.w_ready)  w_valid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  state     <= ST_WR_RESP;
                  b_ready_q <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (mst.b_valid) begin
                  b_ready_q <= 1'b0;
                  if (mst.b_resp[1]) begin
                     state   <= ST_ERR1;
                     s_hresp <= 1'b1;
                  end else begin
                     state         <= ST_DONE;
                     s_hready_resp <= 1'b1;
                  end
               end
            end
            ST_RD_REQ: begin
               if (mst.ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (mst.r_valid) begin
                  r_ready_q <= 1'b0;
                  s_hrdata  <= mst.r_data;
                  if (mst.r_resp[1]) begin
                     state   <= ST_ERR1;
                     s_hresp <= 1'b1;
                  end else begin
                     state         <= ST_DONE;
                     s_hready_resp <= 1'b1;
                  end
               end
            end
            ST_ERR1: begin
               state         <= ST_ERR2;
               s_hready_resp <= 1'b1;
               s_hresp       <= 1'b1;
            end
            default: begin
               state         <= ST_IDLE;
               s_hready_resp <= 1'b1;
               s_hresp       <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

   assign mst.aw_id    = AXI_ID;
   assign mst.aw_addr  = addr_q;
   assign mst.aw_len   = 8'd0;
   assign mst.aw_size  = size_q;
   assign mst.aw_burst = 2'b01;
   assign mst.aw_lock  = 1'b0;
   assign mst.aw_cache = 4'd0;
   assign mst.aw_prot  = 3'd0;
   assign mst.aw_valid = aw_valid_q;

   // AHB holds hwdata stable while the data phase is stretched, so W can pass it straight through.
   assign mst.w_data  = s_hwdata;
   assign mst.w_last  = 1'b1;
   assign mst.w_valid = w_valid_q;

   always_comb begin
      mst.w_strb = 4'hF;
      case (size_q)
         3'd0:    mst.w_strb = 4'b0001 << addr_q[1:0];
         3'd1:    mst.w_strb = 4'b0011 << {addr_q[1], 1'b0};
         default: mst.w_strb = 4'hF;
      endcase
   end

   assign mst.b_ready = b_ready_q;

   assign mst.ar_id    = AXI_ID;
   assign mst.ar_addr  = addr_q;
   assign mst.ar_len   = 8'd0;
   assign mst.ar_size  = size_q;
   assign mst.ar_burst = 2'b01;
   assign mst.ar_lock  = 1'b0;
   assign mst.ar_cache = 4'd0;
   assign mst.ar_prot  = 3'd0;
   assign mst.ar_valid = ar_valid_q;

   assign mst.r_ready = r_ready_q;

   assign unused_inputs = ^{s_hburst, mst.b_id, mst.r_id, mst.r_last, mst.b_resp[0], mst.r_resp[0]};

endmodule

// File: tb/tb_ahb_to_axi_master.sv
// Randomized bench for ahb_to_axi_master: an AHB master driver, a delay-configurable AXI slave
// with a protocol monitor, and a transfer-level reference model feeding expected queues.
module tb_ahb_to_axi_master;

   localparam logic [3:0] TB_ID = 4'h5;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_hsel;
   logic [31:0] s_haddr;
   logic [1:0]  s_htrans;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [2:0]  s_hburst;
   logic [31:0] s_hwdata;
   logic        s_hready;
   logic        s_hready_resp;
   logic        s_hresp;
   logic [31:0] s_hrdata;
   logic [2:0]  dbg_state;

   AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

   assign s_hready = s_hready_resp;

   ahb_to_axi_master #(.ADDR_WIDTH(32), .ID_WIDTH(4), .AXI_ID(TB_ID)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_hsel        (s_hsel),
      .s_haddr       (s_haddr),
      .s_htrans      (s_htrans),
      .s_hwrite      (s_hwrite),
      .s_hsize       (s_hsize),
      .s_hburst      (s_hburst),
      .s_hwdata      (s_hwdata),
      .s_hready      (s_hready),
      .s_hready_resp (s_hready_resp),
      .s_hresp       (s_hresp),
      .s_hrdata      (s_hrdata),
      .dbg_state     (dbg_state),
      .mst           (axi)
   );

   // ---------------- clock ----------------
   always #5 aclk = ~aclk;

   // ---------------- AXI slave model ----------------
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0]  b_resp_cfg, r_resp_cfg;
   logic [31:0] r_data_cfg;

   int   aw_seen, w_seen, b_seen, ar_seen, r_seen;
   logic aw_got, w_got, pend_b, pend_r;
   int   viol;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_now, w_now;

   logic [63:0] aw_log[$];
   logic [63:0] w_log[$];
   logic [63:0] ar_log[$];
   logic [63:0] aw_exp_q[$];
   logic [63:0] w_exp_q[$];
   logic [63:0] ar_exp_q[$];

   assign axi.aw_ready = axi.aw_valid && (aw_seen >= aw_dly);
   assign axi.w_ready  = axi.w_valid && (w_seen >= w_dly);
   assign axi.ar_ready = axi.ar_valid && (ar_seen >= ar_dly);
   assign axi.b_valid  = pend_b && (b_seen >= b_dly);
   assign axi.b_resp   = b_resp_cfg;
   assign axi.b_id     = TB_ID;
   assign axi.r_valid  = pend_r && (r_seen >= r_dly);
   assign axi.r_data   = r_data_cfg;
   assign axi.r_resp   = r_resp_cfg;
   assign axi.r_last   = 1'b1;
   assign axi.r_id     = TB_ID;

   assign aw_hs  = axi.aw_valid && axi.aw_ready;
   assign w_hs   = axi.w_valid && axi.w_ready;
   assign b_hs   = axi.b_valid && axi.b_ready;
   assign ar_hs  = axi.ar_valid && axi.ar_ready;
   assign r_hs   = axi.r_valid && axi.r_ready;
   assign aw_now = aw_got || aw_hs;
   assign w_now  = w_got || w_hs;

   function automatic logic [63:0] pack_a(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst,
                                          input logic [3:0] id, input logic lock,
                                          input logic [3:0] cache, input logic [2:0] prot);
      return {7'd0, addr, size, len, burst, id, lock, cache, prot};
   endfunction

   always @(posedge aclk) begin
      if (areset) begin
         aw_seen <= 0; w_seen <= 0; b_seen <= 0; ar_seen <= 0; r_seen <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; pend_b <= 1'b0; pend_r <= 1'b0;
      end else begin
         aw_seen <= aw_hs ? 0 : (axi.aw_valid ? aw_seen + 1 : 0);
         w_seen  <= w_hs ? 0 : (axi.w_valid ? w_seen + 1 : 0);
         ar_seen <= ar_hs ? 0 : (axi.ar_valid ? ar_seen + 1 : 0);
         b_seen  <= (pend_b && !b_hs) ? b_seen + 1 : 0;
         r_seen  <= (pend_r && !r_hs) ? r_seen + 1 : 0;
         if (aw_hs)
            aw_log.push_back(pack_a(axi.aw_addr, axi.aw_size, axi.aw_len, axi.aw_burst,
                                    axi.aw_id, axi.aw_lock, axi.aw_cache, axi.aw_prot));
         if (w_hs) w_log.push_back({27'd0, axi.w_data, axi.w_strb, axi.w_last});
         if (ar_hs)
            ar_log.push_back(pack_a(axi.ar_addr, axi.ar_size, axi.ar_len, axi.ar_burst,
                                    axi.ar_id, axi.ar_lock, axi.ar_cache, axi.ar_prot));
         if (aw_now && w_now) begin
            pend_b <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            aw_got <= aw_now; w_got <= w_now;
         end
         if (b_hs) pend_b <= 1'b0;
         if (ar_hs) pend_r <= 1'b1;
         if (r_hs) pend_r <= 1'b0;
         // protocol monitor: single outstanding, ready only when a response is owed, no re-sends
         if ((axi.b_ready && !pend_b) || (axi.r_ready && !pend_r) ||
             (axi.aw_valid && aw_got) || (axi.w_valid && w_got) ||
             ((axi.aw_valid || axi.w_valid || axi.ar_valid) && (pend_b || pend_r)))
            viol <= viol + 1;
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model for one AHB transfer under the current slave configuration.
   task automatic check_xfer(input xfer_t x, input int low, input int err_low,
                             input logic hresp_f, input logic [31:0] rd);
      bit bad, err;
      int exp_low, nbytes, ofs;
      logic [3:0] strb;
      bad = (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
      err = bad;
      if (bad) begin
         exp_low = 1;
      end else if (x.write) begin
         nbytes  = 1 << x.size;
         ofs     = int'(x.addr % 4);
         strb    = 4'(((1 << nbytes) - 1) << ofs);
         exp_low = 2 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
         err     = (b_resp_cfg >= 2'd2);
         aw_exp_q.push_back(pack_a(x.addr, x.size, 8'd0, 2'b01, TB_ID, 1'b0, 4'd0, 3'd0));
         w_exp_q.push_back({27'd0, x.wdata, strb, 1'b1});
      end else begin
         exp_low = 2 + ar_dly + r_dly;
         err     = (r_resp_cfg >= 2'd2);
         ar_exp_q.push_back(pack_a(x.addr, x.size, 8'd0, 2'b01, TB_ID, 1'b0, 4'd0, 3'd0));
      end
      if (err && !bad) exp_low = exp_low + 1;
      chk("wait_cycles", 64'(low), 64'(exp_low));
      chk("hresp_final", {63'd0, hresp_f}, {63'd0, err});
      chk("err_cycles", 64'(err_low), err ? 64'd1 : 64'd0);
      if (!bad && !x.write && !err) chk("hrdata", {32'd0, rd}, {32'd0, r_data_cfg});
   endtask

   task automatic check_logs();
      chk("aw_count", 64'(aw_log.size()), 64'(aw_exp_q.size()));
      chk("w_count", 64'(w_log.size()), 64'(w_exp_q.size()));
      chk("ar_count", 64'(ar_log.size()), 64'(ar_exp_q.size()));
      for (int i = 0; i < aw_log.size() && i < aw_exp_q.size(); i++) chk("aw_fields", aw_log[i], aw_exp_q[i]);
      for (int i = 0; i < w_log.size() && i < w_exp_q.size(); i++) chk("w_fields", w_log[i], w_exp_q[i]);
      for (int i = 0; i < ar_log.size() && i < ar_exp_q.size(); i++) chk("ar_fields", ar_log[i], ar_exp_q[i]);
      chk("protocol", 64'(viol), 64'd0);
      aw_log.delete(); w_log.delete(); ar_log.delete();
      aw_exp_q.delete(); w_exp_q.delete(); ar_exp_q.delete();
   endtask

   // ---------------- AHB driver ----------------
   xfer_t seq_q[$];

   task automatic drive_addr(input xfer_t x);
      s_hsel   = 1'b1;
      s_htrans = 2'b10;
      s_haddr  = x.addr;
      s_hwrite = x.write;
      s_hsize  = x.size;
      s_hburst = 3'b000;
   endtask

   task automatic set_cfg(input int awd, input int wd, input int bd, input int ard, input int rd,
                          input logic [1:0] bresp, input logic [1:0] rresp, input logic [31:0] rdata);
      aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
      b_resp_cfg = bresp; r_resp_cfg = rresp; r_data_cfg = rdata;
   endtask

   // Runs seq_q back to back: each next address phase is driven in the previous final data cycle.
   task automatic run_seq();
      int n;
      n = seq_q.size();
      @(posedge aclk); #1;
      drive_addr(seq_q[0]);
      for (int i = 0; i < n; i++) begin
         int low, err_low;
         logic hresp_f;
         logic [31:0] rd;
         @(posedge aclk); #1;
         s_hwdata = seq_q[i].wdata;
         s_hsel   = 1'b0;
         s_htrans = 2'b00;
         low = 0; err_low = 0;
         while (s_hready_resp !== 1'b1 && low < 100) begin
            low++;
            if (s_hresp === 1'b1) err_low++;
            @(posedge aclk); #1;
         end
         hresp_f = s_hresp;
         rd      = s_hrdata;
         if (i + 1 < n) drive_addr(seq_q[i + 1]);
         check_xfer(seq_q[i], low, err_low, hresp_f, rd);
      end
      @(posedge aclk); #1;
      check_logs();
      seq_q.delete();
   endtask

   function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                input logic [31:0] wdata);
      xfer_t x;
      x.addr = addr; x.write = write; x.size = size; x.wdata = wdata;
      return x;
   endfunction

   // ---------------- main ----------------
   initial begin
      areset = 1'b1;
      s_hsel = 1'b0; s_haddr = 32'd0; s_htrans = 2'b00; s_hwrite = 1'b0;
      s_hsize = 3'd0; s_hburst = 3'd0; s_hwdata = 32'd0;
      viol = 0;
      set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_hready", {63'd0, s_hready_resp}, 64'd1);
      chk("rst_hresp", {63'd0, s_hresp}, 64'd0);
      chk("rst_hrdata", {32'd0, s_hrdata}, 64'd0);
      chk("rst_valids", {61'd0, axi.aw_valid, axi.w_valid, axi.ar_valid}, 64'd0);
      chk("rst_readys", {62'd0, axi.b_ready, axi.r_ready}, 64'd0);
      areset = 1'b0;

      // BUSY and IDLE transfers get zero-wait OKAY without touching AXI
      @(posedge aclk); #1;
      s_hsel = 1'b1; s_htrans = 2'b01; s_haddr = 32'h8000_0000; s_hwrite = 1'b1;
      @(posedge aclk); #1;
      chk("busy_hready", {62'd0, s_hready_resp, s_hresp}, 64'd2);
      s_htrans = 2'b00;
      @(posedge aclk); #1;
      chk("idle_hready", {62'd0, s_hready_resp, s_hresp}, 64'd2);
      s_hsel = 1'b0;
      check_logs();

      // word write
      set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
      seq_q.push_back(mk(32'h8000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF));
      run_seq();

      // byte and halfword strobes
      seq_q.push_back(mk(32'h8000_0003, 1'b1, 3'd0, 32'hAABB_CCDD));
      seq_q.push_back(mk(32'h8000_0002, 1'b1, 3'd1, 32'h1122_3344));
      run_seq();

      // read with late R
      set_cfg(0, 0, 0, 0, 5, 2'b00, 2'b00, 32'h1234_5678);
      seq_q.push_back(mk(32'h8000_0020, 1'b0, 3'd2, 32'd0));
      run_seq();

      // error paths
      set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b10, 32'hCAFE_0001);
      seq_q.push_back(mk(32'h8000_0024, 1'b0, 3'd2, 32'd0));
      seq_q.push_back(mk(32'h8000_0028, 1'b1, 3'd3, 32'h5555_AAAA));
      seq_q.push_back(mk(32'h8000_0031, 1'b0, 3'd1, 32'd0));
      run_seq();
      set_cfg(0, 0, 1, 0, 0, 2'b11, 2'b00, 32'd0);
      seq_q.push_back(mk(32'h8000_0034, 1'b1, 3'd2, 32'h0F0F_0F0F));
      run_seq();

      // late AW, immediate W
      set_cfg(4, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
      seq_q.push_back(mk(32'h8000_0044, 1'b1, 3'd2, 32'h7777_8888));
      run_seq();

      // back-to-back write then read
      set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h9ABC_DEF0);
      seq_q.push_back(mk(32'h8000_0050, 1'b1, 3'd2, 32'h0102_0304));
      seq_q.push_back(mk(32'h8000_0060, 1'b0, 3'd2, 32'd0));
      run_seq();

      // reset while waiting for B
      set_cfg(0, 0, 20, 0, 0, 2'b00, 2'b00, 32'd0);
      @(posedge aclk); #1;
      drive_addr(mk(32'h8000_0070, 1'b1, 3'd2, 32'd0));
      @(posedge aclk); #1;
      s_hwdata = 32'h3141_5926; s_hsel = 1'b0; s_htrans = 2'b00;
      @(posedge aclk); #1;
      chk("pre_rst_bready", {63'd0, axi.b_ready}, 64'd1);
      areset = 1'b1;
      @(posedge aclk); #1;
      chk("mid_rst_resp", {61'd0, s_hready_resp, s_hresp, axi.b_ready}, 64'd4);
      areset = 1'b0;
      aw_log.delete(); w_log.delete();

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         int n;
         n = $urandom_range(1, 3);
         set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'b00,
                 ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'b00,
                 $urandom);
         for (int k = 0; k < n; k++) begin
            logic [2:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            ad = 32'h8000_0000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1 && sz <= 3'd2) ad = ad & ~((32'd1 << sz) - 32'd1);
            seq_q.push_back(mk(ad, 1'($urandom_range(0, 1)), sz, $urandom));
         end
         run_seq();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
